// File: rtl/hub75_pkg.sv
// hub75_pkg: shared types and helpers for the HUB75 scan driver
//   state_t     scan FSM states
//   *_SLICE     channel position inside a {R,G,B} pixel word, in units of BPC bits
//   plane_time  OE on-time of a bit-plane in clk cycles
package hub75_pkg;
   typedef enum logic [2:0] {IDLE, SHIFT, BLANK, LATCH, DISPLAY} state_t;
   localparam int R_SLICE = 2;
   localparam int G_SLICE = 1;
   localparam int B_SLICE = 0;
   function automatic int plane_time(input int base, input int plane);
      return base << plane;
   endfunction
endpackage

// File: rtl/hub75_bcm_timer.sv
// hub75_bcm_timer: binary-code-modulation display timer for one bit-plane
//   clk, rst    clock, synchronous active-high reset
//   start       pulse in the cycle before DISPLAY; loads plane time (and brightness)
//   plane       current bit-plane
//   brightness  8-bit OE duty scale, only with HUB75_BRIGHTNESS_EN defined
//   OE          output enable, active low, registered
//   done        high in the last DISPLAY cycle
module hub75_bcm_timer
   import hub75_pkg::*;
#(
   parameter int BASE_TICKS = 16,
   parameter int BPC = 4,
   localparam int PW = BPC > 1 ? $clog2(BPC) : 1,
   localparam int TW = $clog2(BASE_TICKS << (BPC - 1)) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [PW-1:0] plane,
`ifdef HUB75_BRIGHTNESS_EN
   input  logic [7:0]    brightness,
`endif
   output logic          OE,
   output logic          done
);
   logic [TW-1:0] full, on, cnt, lim, on_lim;
   logic run;
   assign full = TW'(plane_time(BASE_TICKS, int'(plane)));
`ifdef HUB75_BRIGHTNESS_EN
   logic [TW+8:0] prod;
   assign prod = (TW+9)'(full) * (TW+9)'({1'b0, brightness} + 9'd1);
   assign on = TW'(prod >> 8);
`else
   assign on = full;
`endif
   // cnt is the 1-based index of the current DISPLAY cycle
   assign done = run && cnt == lim;
   always_ff @(posedge clk) begin
      if (rst) begin
         run <= 1'b0;
         cnt <= '0;
         lim <= '0;
         on_lim <= '0;
         OE <= 1'b1;
      end else if (start) begin
         run <= 1'b1;
         cnt <= TW'(1);
         lim <= full;
         on_lim <= on;
         OE <= on == '0;
      end else if (done) begin
         run <= 1'b0;
         OE <= 1'b1;
      end else if (run) begin
         cnt <= cnt + 1'b1;
         OE <= cnt >= on_lim;
      end
   end
endmodule

// File: rtl/hub75_scan_driver.sv
// hub75_scan_driver: HUB75 LED-matrix scan engine (shift, blank, latch, BCM display per bit-plane)
//   clk, rst            clock, synchronous active-high reset
//   enable              run scanning, sampled at row/plane boundaries
//   rd_en/rd_row/rd_col framebuffer read request; rd_top/rd_bot return 1 clk later
//   brightness          OE duty scale, only with HUB75_BRIGHTNESS_EN defined
//   panel_clk           panel shift clock
//   R0,G0,B0,R1,G1,B1   top/bottom half data bits
//   row_sel             row address, bit0 = A
//   LAT, OE             latch (high), output enable (low)
//   frame_done          1-clk pulse after the last plane of the last row
module hub75_scan_driver
   import hub75_pkg::*;
#(
   parameter int COLS = 64,
   parameter int ROW_ADDR_W = 4,
   parameter int BPC = 4,
   parameter int BASE_TICKS = 16,
   parameter int CLK_DIV = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   output logic                    rd_en,
   output logic [ROW_ADDR_W-1:0]   rd_row,
   output logic [$clog2(COLS)-1:0] rd_col,
   input  logic [3*BPC-1:0]        rd_top,
   input  logic [3*BPC-1:0]        rd_bot,
`ifdef HUB75_BRIGHTNESS_EN
   input  logic [7:0]              brightness,
`endif
   output logic                    panel_clk,
   output logic                    R0,
   output logic                    G0,
   output logic                    B0,
   output logic                    R1,
   output logic                    G1,
   output logic                    B1,
   output logic [ROW_ADDR_W-1:0]   row_sel,
   output logic                    LAT,
   output logic                    OE,
   output logic                    frame_done
);
   localparam int CW = $clog2(COLS);
   localparam int PW = BPC > 1 ? $clog2(BPC) : 1;
   // per column: fetch, data return, CLK_DIV low, CLK_DIV high
   localparam int SC_MAX = 2 * CLK_DIV + 1;
   localparam int SW = $clog2(SC_MAX + 1);
   state_t state;
   logic [CW-1:0] col;
   logic [SW-1:0] sc;
   logic [ROW_ADDR_W-1:0] row;
   logic [PW-1:0] plane;
   logic [BPC-1:0] sl [6];
   logic last_sc, last_col, last_plane, last_row, tmr_done;
   assign last_sc = sc == SW'(SC_MAX);
   assign last_col = col == CW'(COLS - 1);
   assign last_plane = plane == PW'(BPC - 1);
   assign last_row = &row;
   assign rd_row = row;
   assign rd_col = col;
   assign sl[0] = rd_top[R_SLICE*BPC +: BPC];
   assign sl[1] = rd_top[G_SLICE*BPC +: BPC];
   assign sl[2] = rd_top[B_SLICE*BPC +: BPC];
   assign sl[3] = rd_bot[R_SLICE*BPC +: BPC];
   assign sl[4] = rd_bot[G_SLICE*BPC +: BPC];
   assign sl[5] = rd_bot[B_SLICE*BPC +: BPC];
   hub75_bcm_timer #(.BASE_TICKS(BASE_TICKS), .BPC(BPC)) u_tmr (
      .clk(clk),
      .rst(rst),
      .start(state == LATCH),
      .plane(plane),
`ifdef HUB75_BRIGHTNESS_EN
      .brightness(brightness),
`endif
      .OE(OE),
      .done(tmr_done)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         row <= '0;
         plane <= '0;
         col <= '0;
         sc <= '0;
         rd_en <= 1'b0;
         panel_clk <= 1'b0;
         {R0, G0, B0, R1, G1, B1} <= '0;
         row_sel <= '0;
         LAT <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: if (enable) begin
               state <= SHIFT;
               col <= '0;
               sc <= '0;
               rd_en <= 1'b1;
            end
            SHIFT: begin
               sc <= last_sc ? '0 : sc + 1'b1;
               col <= last_sc && !last_col ? col + 1'b1 : col;
               rd_en <= last_sc && !last_col;
               panel_clk <= !last_sc && int'(sc) + 1 >= CLK_DIV + 2;
               if (sc == SW'(1))
                  {R0, G0, B0, R1, G1, B1} <= {sl[0][plane], sl[1][plane], sl[2][plane],
                                               sl[3][plane], sl[4][plane], sl[5][plane]};
               if (last_sc && last_col)
                  state <= BLANK;
            end
            BLANK: begin
               row_sel <= row;
               LAT <= 1'b1;
               state <= LATCH;
            end
            LATCH: begin
               LAT <= 1'b0;
               state <= DISPLAY;
            end
            DISPLAY: if (tmr_done) begin
               plane <= last_plane ? '0 : plane + 1'b1;
               row <= last_plane ? row + 1'b1 : row;
               frame_done <= last_plane && last_row;
               state <= enable ? SHIFT : IDLE;
               col <= '0;
               sc <= '0;
               rd_en <= enable;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_hub75_scan_driver.sv
// tb_hub75_scan_driver: directed self-checking bench for hub75_scan_driver (COLS=8, 4 rows, BPC=2, BASE_TICKS=4)
module tb_hub75_scan_driver;
   localparam int COLS = 8;
   localparam int RW = 2;
   localparam int BPC = 2;
   logic clk = 1'b0, rst = 1'b1, enable = 1'b0, clr = 1'b0;
   logic rd_en, panel_clk, R0, G0, B0, R1, G1, B1, LAT, OE, frame_done;
   logic [RW-1:0] rd_row, row_sel;
   logic [2:0] rd_col;
   logic [5:0] rd_top = '0, rd_bot = '0;
`ifdef HUB75_BRIGHTNESS_EN
   logic [7:0] brightness = 8'd255;
`endif
   logic [5:0] top_mem [COLS];
   logic [5:0] bot_mem [COLS];
   int npass = 0, ntotal = 0;
   int n_lat, n_oe, rise_cnt, oe_run, lat_run, n_fd, fd_hi, fd_at_oe, cyc;
   int lat_rises [64], lat_row [64], lat_len [64], lat_t [64], oe_len [64];
   logic lat_oe [64];
   logic [7:0] lat_dat [64][6];
   logic [7:0] sr [6];
   logic pclk_q, lat_q, fd_q;
   logic [5:0] ch;

   hub75_scan_driver #(.COLS(COLS), .ROW_ADDR_W(RW), .BPC(BPC), .BASE_TICKS(4), .CLK_DIV(1)) dut (
      .clk(clk), .rst(rst), .enable(enable),
      .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .rd_top(rd_top), .rd_bot(rd_bot),
`ifdef HUB75_BRIGHTNESS_EN
      .brightness(brightness),
`endif
      .panel_clk(panel_clk), .R0(R0), .G0(G0), .B0(B0), .R1(R1), .G1(G1), .B1(B1),
      .row_sel(row_sel), .LAT(LAT), .OE(OE), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (rd_en) begin
         rd_top <= top_mem[rd_col];
         rd_bot <= bot_mem[rd_col];
      end

   initial forever begin
      @(negedge clk);
      cyc++;
      if (clr) begin
         n_lat = 0; n_oe = 0; rise_cnt = 0; oe_run = 0; lat_run = 0;
         n_fd = 0; fd_hi = 0; fd_at_oe = 0; pclk_q = 0; lat_q = 0; fd_q = 0;
         for (int k = 0; k < 6; k++) sr[k] = '0;
      end else begin
         if (panel_clk && !pclk_q) begin
            rise_cnt++;
            ch = {R0, G0, B0, R1, G1, B1};
            for (int k = 0; k < 6; k++) sr[k] = {sr[k][6:0], ch[5-k]};
         end
         if (!OE) oe_run++;
         else if (oe_run > 0) begin
            if (n_oe < 64) oe_len[n_oe] = oe_run;
            n_oe++;
            oe_run = 0;
         end
         if (LAT) begin
            lat_run++;
            if (!lat_q) begin
               if (n_lat < 64) begin
                  lat_rises[n_lat] = rise_cnt;
                  lat_row[n_lat] = int'(row_sel);
                  lat_oe[n_lat] = OE;
                  lat_t[n_lat] = cyc;
                  for (int k = 0; k < 6; k++) lat_dat[n_lat][k] = sr[k];
               end
               n_lat++;
               rise_cnt = 0;
            end
         end else if (lat_q) begin
            if (n_lat <= 64) lat_len[n_lat-1] = lat_run;
            lat_run = 0;
         end
         if (frame_done) begin
            fd_hi++;
            if (!fd_q) begin
               n_fd++;
               fd_at_oe = n_oe;
            end
         end
         pclk_q = panel_clk; lat_q = LAT; fd_q = frame_done;
      end
   end

   task automatic do_reset(input logic en);
      rst = 1'b1; enable = en; clr = 1'b1;
      repeat (5) @(negedge clk);
      clr = 1'b0; rst = 1'b0;
   endtask

   task automatic test_reset;
      int n;
      rst = 1'b1; enable = 1'b1; clr = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         ntotal++;
         if ({OE, LAT, panel_clk, rd_en, frame_done, row_sel} !== 7'b1000000)
            $display("FAIL reset_outputs: OE,LAT,pclk,rd_en,fd,row_sel got %b expected 1000000",
                     {OE, LAT, panel_clk, rd_en, frame_done, row_sel});
         else npass++;
      end
      ntotal++;
      if ({R0, G0, B0, R1, G1, B1} !== 6'b0) $display("FAIL reset_rgb: got %b expected 000000", {R0, G0, B0, R1, G1, B1});
      else npass++;
      clr = 1'b0; rst = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rd_en && n < 10);
      ntotal++;
      if (n !== 1) $display("FAIL first_rd_en_latency: got %0d expected 1", n);
      else npass++;
      ntotal++;
      if ({rd_row, rd_col, OE} !== 6'b000001) $display("FAIL first_read_addr: row,col,OE got %b expected 000001", {rd_row, rd_col, OE});
      else npass++;
   endtask

   task automatic test_frame;
      for (int c = 0; c < COLS; c++) begin top_mem[c] = 6'b10_00_00; bot_mem[c] = '0; end
      do_reset(1'b1);
      for (int i = 0; i < 1000 && n_fd == 0; i++) @(negedge clk);
      ntotal++;
      if (n_fd !== 1) $display("FAIL frame_done_count: got %0d expected 1", n_fd); else npass++;
      ntotal++;
      if (fd_at_oe !== 8) $display("FAIL frame_done_after_plane: got %0d displays expected 8", fd_at_oe); else npass++;
      ntotal++;
      if (n_lat !== 8) $display("FAIL lat_per_frame: got %0d expected 8", n_lat); else npass++;
      for (int i = 0; i < 8; i++) begin
         ntotal++;
         if (lat_rises[i] !== 8) $display("FAIL pclk_rises[%0d]: got %0d expected 8", i, lat_rises[i]); else npass++;
         ntotal++;
         if (lat_len[i] !== 1) $display("FAIL lat_width[%0d]: got %0d expected 1", i, lat_len[i]); else npass++;
         ntotal++;
         if (lat_oe[i] !== 1'b1) $display("FAIL oe_during_lat[%0d]: got %b expected 1", i, lat_oe[i]); else npass++;
         ntotal++;
         if (lat_row[i] !== i / 2) $display("FAIL row_sel[%0d]: got %0d expected %0d", i, lat_row[i], i / 2); else npass++;
         ntotal++;
         if (oe_len[i] !== (i % 2 ? 8 : 4)) $display("FAIL oe_low[%0d]: got %0d expected %0d", i, oe_len[i], i % 2 ? 8 : 4); else npass++;
         ntotal++;
         if (lat_dat[i][0] !== (i % 2 ? 8'hFF : 8'h00)) $display("FAIL r0_bits[%0d]: got %h expected %h", i, lat_dat[i][0], i % 2 ? 8'hFF : 8'h00); else npass++;
         ntotal++;
         if ({lat_dat[i][1], lat_dat[i][2], lat_dat[i][3], lat_dat[i][4], lat_dat[i][5]} !== 40'h0)
            $display("FAIL other_bits[%0d]: got %h expected 0", i, {lat_dat[i][1], lat_dat[i][2], lat_dat[i][3], lat_dat[i][4], lat_dat[i][5]});
         else npass++;
      end
      ntotal++;
      if (lat_t[1] - lat_t[0] !== 38) $display("FAIL plane0_period: got %0d expected 38", lat_t[1] - lat_t[0]); else npass++;
      ntotal++;
      if (lat_t[2] - lat_t[1] !== 42) $display("FAIL plane1_period: got %0d expected 42", lat_t[2] - lat_t[1]); else npass++;
      for (int i = 0; i < 200 && n_lat < 9; i++) @(negedge clk);
      ntotal++;
      if (n_lat < 9 || lat_row[8] !== 0) $display("FAIL row_wrap: lat count %0d row %0d expected row 0", n_lat, lat_row[8]); else npass++;
      ntotal++;
      if (fd_hi !== 1) $display("FAIL frame_done_width: got %0d expected 1", fd_hi); else npass++;
   endtask

   task automatic test_patterns;
      logic [5:0] m;
      logic [7:0] e;
      top_mem = '{6'h3F, 6'h00, 6'h15, 6'h2A, 6'h21, 6'h12, 6'h0C, 6'h33};
      bot_mem = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h3C, 6'h03};
      do_reset(1'b1);
      for (int i = 0; i < 200 && n_lat < 2; i++) @(negedge clk);
      for (int p = 0; p < 2; p++)
         for (int k = 0; k < 6; k++) begin
            for (int c = 0; c < COLS; c++) begin
               m = k < 3 ? top_mem[c] : bot_mem[c];
               e[7-c] = m[(2 - k % 3) * BPC + p];
            end
            ntotal++;
            if (n_lat < 2 || lat_dat[p][k] !== e) $display("FAIL pattern p%0d ch%0d: got %h expected %h", p, k, lat_dat[p][k], e);
            else npass++;
         end
   endtask

   task automatic test_enable_stop;
      do_reset(1'b1);
      for (int i = 0; i < 200 && n_lat < 1; i++) @(negedge clk);
      enable = 1'b0;
      repeat (100) @(negedge clk);
      ntotal++;
      if (n_lat !== 1 || n_oe !== 1) $display("FAIL stop_counts: lat %0d oe %0d expected 1 1", n_lat, n_oe); else npass++;
      ntotal++;
      if (oe_len[0] !== 4) $display("FAIL stop_display_len: got %0d expected 4", oe_len[0]); else npass++;
      ntotal++;
      if ({OE, rd_en, panel_clk} !== 3'b100) $display("FAIL idle_outputs: OE,rd_en,pclk got %b expected 100", {OE, rd_en, panel_clk}); else npass++;
      enable = 1'b1;
      for (int i = 0; i < 200 && n_oe < 2; i++) @(negedge clk);
      ntotal++;
      if (n_oe < 2 || oe_len[1] !== 8) $display("FAIL resume_next_plane: got %0d expected 8", oe_len[1]); else npass++;
      ntotal++;
      if (lat_row[1] !== 0) $display("FAIL resume_row: got %0d expected 0", lat_row[1]); else npass++;
   endtask

   task automatic test_midreset;
      do_reset(1'b1);
      for (int i = 0; i < 300 && n_lat < 3; i++) @(negedge clk);
      for (int i = 0; i < 50 && OE; i++) @(negedge clk);
      @(negedge clk);
      ntotal++;
      if ({OE, row_sel} !== 3'b001) $display("FAIL pre_reset_display: OE,row_sel got %b expected 001", {OE, row_sel}); else npass++;
      rst = 1'b1;
      @(negedge clk);
      ntotal++;
      if ({OE, LAT, rd_en, panel_clk, frame_done, row_sel} !== 7'b1000000)
         $display("FAIL midreset_outputs: OE,LAT,rd_en,pclk,fd,row_sel got %b expected 1000000", {OE, LAT, rd_en, panel_clk, frame_done, row_sel});
      else npass++;
      ntotal++;
      if ({R0, G0, B0, R1, G1, B1} !== 6'b0) $display("FAIL midreset_rgb: got %b expected 000000", {R0, G0, B0, R1, G1, B1}); else npass++;
      rst = 1'b0;
   endtask

`ifdef HUB75_BRIGHTNESS_EN
   task automatic test_brightness;
      brightness = 8'd127;
      do_reset(1'b1);
      for (int i = 0; i < 300 && n_lat < 3; i++) @(negedge clk);
      ntotal++;
      if (oe_len[0] !== 2) $display("FAIL bright_plane0: got %0d expected 2", oe_len[0]); else npass++;
      ntotal++;
      if (oe_len[1] !== 4) $display("FAIL bright_plane1: got %0d expected 4", oe_len[1]); else npass++;
      ntotal++;
      if (lat_t[1] - lat_t[0] !== 38) $display("FAIL bright_period: got %0d expected 38", lat_t[1] - lat_t[0]); else npass++;
      brightness = 8'd255;
   endtask
`endif

   initial begin
      for (int c = 0; c < COLS; c++) begin top_mem[c] = 6'b10_00_00; bot_mem[c] = '0; end
      test_reset();
      test_frame();
      test_patterns();
      test_enable_stop();
      test_midreset();
`ifdef HUB75_BRIGHTNESS_EN
      test_brightness();
`endif
      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end
endmodule
